// File: rtl/systolic_edge_feeder_pkg.sv
// Shared definitions for the systolic array edge feeders, PEs and array top level.
// Holds the feeder state encoding, array-wide default sizes and the lane slicing helper.
package systolic_edge_feeder_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_t;

   // Lane i of a packed N*DW vector occupies [lane_lsb(i, DW) +: DW].
   function automatic int lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/systolic_edge_feeder_skew_lane.sv
// One lane of the skew datapath: a DEPTH-stage shift register that only moves on shift.
// The last stage drives the array edge for this lane.
module skew_lane #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          shift,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] sr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) sr[s] <= '0;
      end else if (shift) begin
         sr[0] <= d;
         for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for an N x N systolic MAC array: accepts operand vectors, skews lane i by i
// steps into a diagonal wavefront, then feeds FLUSH_LEN zero steps to drain the array.
module systolic_edge_feeder
   import systolic_edge_feeder_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int DW        = DEF_DW,
   parameter int KW        = 8,
   parameter int FLUSH_LEN = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   output logic [N*DW-1:0] edge_data,
   output logic            edge_en,
   output logic            busy,
   output logic            done,
   output feeder_state_t   state_dbg
);

   localparam int FCW = $clog2(FLUSH_LEN + 1);

   feeder_state_t  state_q, state_d;
   logic [KW-1:0]  k_q;
   logic [KW-1:0]  beat_q;
   logic [KW-1:0]  beat_inc;
   logic [FCW-1:0] flush_q;
   logic [FCW-1:0] flush_inc;
   logic           accept;
   logic           step;
   logic           last_beat;
   logic           last_flush;

   // Handshake: a vector transfers on any rising edge where in_valid & in_ready are both
   // high; in_ready depends only on state, so in_data/in_valid may not influence it.
   assign in_ready   = (state_q == ST_FEED);
   assign accept     = in_valid & in_ready;
   assign step       = accept | (state_q == ST_FLUSH);
   assign beat_inc   = beat_q + 1'b1;
   assign flush_inc  = flush_q + 1'b1;
   assign last_beat  = (beat_inc == k_q);
   assign last_flush = (flush_q == FCW'(FLUSH_LEN - 1));
   assign state_dbg  = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = (k_len == '0) ? ST_DONE : ST_FEED;
         end
         ST_FEED: begin
            if (accept && last_beat) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (last_flush) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  k_q    <= k_len;
                  beat_q <= '0;
               end
            end
            ST_FEED: begin
               flush_q <= '0;
               if (accept) beat_q <= beat_inc;
            end
            ST_FLUSH: begin
               flush_q <= flush_inc;
            end
            default: begin
            end
         endcase
      end
   end

   // edge_en marks the cycles after a step, i.e. when edge_data holds a fresh wavefront.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         edge_en <= step;
         busy    <= (state_q != ST_IDLE);
         done    <= (state_q == ST_DONE);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] lane_d;

      // Zeros enter stage 0 while flushing so the array drains with neutral operands.
      assign lane_d = (state_q == ST_FEED) ? in_data[lane_lsb(i, DW) +: DW] : '0;

      skew_lane #(
         .DW   (DW),
         .DEPTH(i + 1)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .shift(step),
         .d    (lane_d),
         .q    (edge_data[lane_lsb(i, DW) +: DW])
      );
   end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Bench for systolic_edge_feeder: directed jobs with hand-computed wavefronts, checked by
// edge_en and done monitors against expected queues.
module tb_systolic_edge_feeder;
   import systolic_edge_feeder_pkg::*;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int KW        = 8;
   localparam int FLUSH_LEN = 16;
   localparam int W         = N * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [W-1:0]  edge_data;
   logic          edge_en;
   logic          busy;
   logic          done;
   feeder_state_t state_dbg;

   logic [W-1:0] exp_q[$];
   int           done_exp_q[$];
   int           n_chk  = 0;
   int           n_pass = 0;
   int           en_cnt = 0;

   localparam logic [W-1:0] V0 = 32'h04030201;
   localparam logic [W-1:0] V1 = 32'h08070605;

   systolic_edge_feeder #(
      .N(N), .DW(DW), .KW(KW), .FLUSH_LEN(FLUSH_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .edge_data(edge_data),
      .edge_en  (edge_en),
      .busy     (busy),
      .done     (done),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // scoreboard monitors
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            en_cnt = 0;
         end else begin
            if (edge_en) begin
               en_cnt++;
               if (exp_q.size() == 0) chk("edge_unexpected", edge_data, '0);
               else chk("edge_data", edge_data, exp_q.pop_front());
            end
            if (done) begin
               if (done_exp_q.size() == 0) chk("done_unexpected", 1, 0);
               else chk("done_beats", en_cnt, done_exp_q.pop_front());
               en_cnt = 0;
            end
         end
      end
   end

   // driver tasks
   task automatic do_start(input int k);
      start = 1'b1;
      k_len = KW'(k);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_vec(input logic [W-1:0] v, output bit ok);
      int n = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      while (!ok && n < 50) begin
         ok = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", done, 1);
      @(posedge clk); #1;
      chk("done_single", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic push_b2b();
      exp_q.push_back(32'h00000001);
      exp_q.push_back(32'h00000205);
      exp_q.push_back(32'h00030600);
      exp_q.push_back(32'h04070000);
      exp_q.push_back(32'h08000000);
      for (int t = 0; t < 13; t++) exp_q.push_back('0);
      done_exp_q.push_back(2 + FLUSH_LEN);
   endtask

   // Wavefront model: lane i at step t carries vector t-i, zero outside the job.
   task automatic push_wave(input logic [W-1:0] vecs[$]);
      int k = vecs.size();
      for (int t = 0; t < k + FLUSH_LEN; t++) begin
         logic [W-1:0] w = '0;
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < k) w[i*DW +: DW] = vecs[t-i][i*DW +: DW];
         end
         exp_q.push_back(w);
      end
      done_exp_q.push_back(k + FLUSH_LEN);
   endtask

   task automatic run_b2b(input int gap, input bit poke_start);
      bit ok;
      push_b2b();
      do_start(2);
      send_vec(V0, ok);
      chk("v0_edge_en", edge_en, 1);
      chk("v0_edge_data", edge_data, 32'h00000001);
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         chk("stall_edge_en", edge_en, 0);
         chk("stall_edge_data", edge_data, 32'h00000001);
      end
      if (poke_start) begin
         start = 1'b1;
         k_len = 8'd9;
         @(posedge clk); #1;
         start = 1'b0;
         k_len = 8'd2;
         chk("poke_busy", busy, 1);
      end
      send_vec(V1, ok);
      if (gap == 0 && !poke_start) begin
         for (int c = 0; c < 17; c++) begin
            chk("b2b_edge_en_run", edge_en, 1);
            @(posedge clk); #1;
         end
         chk("b2b_edge_en_end", edge_en, 0);
      end
      wait_done(40);
   endtask

   // main sequence
   initial begin
      bit           ok;
      int           acc;
      logic [W-1:0] vecs[$];

      repeat (3) @(posedge clk);
      #1;
      chk("rst_edge_en", edge_en, 0);
      chk("rst_edge_data", edge_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_state", state_dbg, ST_IDLE);

      run_b2b(0, 1'b0);
      run_b2b(3, 1'b0);

      // k_len = 0: straight to DONE
      done_exp_q.push_back(0);
      do_start(0);
      chk("k0_busy_c1", busy, 0);
      chk("k0_ready_c1", in_ready, 0);
      @(posedge clk); #1;
      chk("k0_busy_c2", busy, 1);
      chk("k0_done_c2", done, 1);
      chk("k0_ready_c2", in_ready, 0);
      chk("k0_edge_en", edge_en, 0);
      @(posedge clk); #1;
      chk("k0_busy_c3", busy, 0);
      chk("k0_done_c3", done, 0);

      run_b2b(0, 1'b1);

      // reset mid-FLUSH
      push_b2b();
      do_start(2);
      send_vec(V0, ok);
      send_vec(V1, ok);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_edge_en", edge_en, 0);
      chk("midrst_edge_data", edge_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_state", state_dbg, ST_IDLE);
      exp_q.delete();
      done_exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("postrst_state", state_dbg, ST_IDLE);
      run_b2b(0, 1'b0);

      // k_len = 255 with random in_valid gaps
      for (int j = 0; j < 255; j++) vecs.push_back(W'($urandom));
      push_wave(vecs);
      do_start(255);
      acc = 0;
      for (int j = 0; j < 255; j++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send_vec(vecs[j], ok);
         if (ok) acc++;
      end
      chk("k255_accepts", acc, 255);
      chk("k255_ready_drop", in_ready, 0);
      wait_done(60);

      repeat (4) @(posedge clk);
      #1;
      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_q_empty", done_exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
